lua_fetch_unit: RTL and testbench

Instruction-fetch stage of the Lua bytecode processor. It consumes the one-hot IF phase enable from the phase generator and owns the program counter. It fetches 32-bit Lua 5.1 instruction words from instruction memory over a valid/ready handshake and presents them, with their PC, to the decode stage. It accepts PC redirects from the execute stage and discards any fetch made stale by a redirect.

---
 rtl/lua_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_lua_fetch_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lua_fetch_unit.sv
// Instruction-fetch stage for the Lua bytecode processor.
// Owns the program counter, issues one word fetch per IF phase over a
// valid/ready handshake, holds the fetched word for decode, and discards
// any response made stale by a PC redirect from execute.
module lua_fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  phase_if,
  input  logic                  stall,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_value,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [5:0]            instr_op,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  id_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                  state_reg,       state_next;
  logic [ADDR_WIDTH-1:0]   pc_reg,          pc_next;
  logic                    pending_reg,     pending_next;
  logic                    drop_reg,        drop_next;
  logic                    imem_req_reg,    imem_req_next;
  logic [ADDR_WIDTH-1:0]   imem_addr_reg,   imem_addr_next;
  logic                    instr_valid_reg, instr_valid_next;
  logic [DATA_WIDTH-1:0]   instr_reg,       instr_next;
  logic [ADDR_WIDTH-1:0]   instr_pc_reg,    instr_pc_next;

  logic trigger;
  logic can_start;

  // A fetch may start when a phase pulse (live or remembered) is present,
  // nothing is stalling, and the decode slot is free or being freed now.
  // A redirect in the same cycle blocks the start so the request never
  // goes out with the PC that is about to be replaced; the pending flag
  // keeps the trigger alive for the next cycle.
  assign trigger   = phase_if | pending_reg;
  assign can_start = trigger & ~stall & (~instr_valid_reg | id_ack) & ~pc_load;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    pending_next     = pending_reg | phase_if;
    drop_next        = drop_reg;
    imem_req_next    = imem_req_reg;
    imem_addr_next   = imem_addr_reg;
    instr_valid_next = instr_valid_reg & ~id_ack;
    instr_next       = instr_reg;
    instr_pc_next    = instr_pc_reg;

    unique case (state_reg)
      IDLE: begin
        if (can_start) begin
          state_next     = REQ;
          imem_req_next  = 1'b1;
          imem_addr_next = pc_reg;
          pending_next   = 1'b0;
        end
      end
      REQ: begin
        if (imem_ready) begin
          imem_req_next = 1'b0;
          if (drop_reg || pc_load) begin
            // Stale response: swallow it and leave pc alone.
            drop_next  = 1'b0;
            state_next = IDLE;
          end else begin
            instr_next       = imem_rdata;
            instr_pc_next    = imem_addr_reg;
            instr_valid_next = 1'b1;
            pc_next          = pc_reg + 1'b1;
            state_next       = HOLD;
          end
        end else if (pc_load) begin
          // The request cannot be withdrawn, so mark its answer as stale.
          drop_next = 1'b1;
        end
      end
      HOLD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Redirect wins over any load or acknowledge in the same cycle.
    if (pc_load) begin
      pc_next          = pc_load_value;
      instr_valid_next = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      pending_reg     <= 1'b0;
      drop_reg        <= 1'b0;
      imem_req_reg    <= 1'b0;
      imem_addr_reg   <= RESET_PC;
      instr_valid_reg <= 1'b0;
      instr_reg       <= '0;
      instr_pc_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pending_reg     <= pending_next;
      drop_reg        <= drop_next;
      imem_req_reg    <= imem_req_next;
      imem_addr_reg   <= imem_addr_next;
      instr_valid_reg <= instr_valid_next;
      instr_reg       <= instr_next;
      instr_pc_reg    <= instr_pc_next;
    end
  end

  assign imem_req    = imem_req_reg;
  assign imem_addr   = imem_addr_reg;
  assign instr_valid = instr_valid_reg;
  assign instr       = instr_reg;
  assign instr_op    = instr_reg[5:0];
  assign instr_pc    = instr_pc_reg;

endmodule

// File: tb/tb_lua_fetch_unit.sv
// Directed, cycle-by-cycle bench for lua_fetch_unit (RESET_PC = 0x0010).
// Each vector gives the inputs for one clock edge and the outputs
// expected just after that edge.
module tb_lua_fetch_unit;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          phase_if;
  logic          stall;
  logic          pc_load;
  logic [AW-1:0] pc_load_value;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ready;
  logic [DW-1:0] imem_rdata;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [5:0]    instr_op;
  logic [AW-1:0] instr_pc;
  logic          id_ack;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string         name;
    logic          rst, ph, st, ld;
    logic [AW-1:0] ldv;
    logic          rdy;
    logic [DW-1:0] rdata;
    logic          ack;
    logic          req;
    logic [AW-1:0] addr;
    logic          v;
    logic [DW-1:0] ins;
    logic [AW-1:0] ipc;
  } vec_t;

  vec_t tbl[$];

  lua_fetch_unit #(
    .ADDR_WIDTH(AW),
    .RESET_PC  (16'h0010),
    .DATA_WIDTH(DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .phase_if     (phase_if),
    .stall        (stall),
    .pc_load      (pc_load),
    .pc_load_value(pc_load_value),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_op     (instr_op),
    .instr_pc     (instr_pc),
    .id_ack       (id_ack)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string name,
                              input logic rst, input logic ph, input logic st,
                              input logic ld, input logic [AW-1:0] ldv,
                              input logic rdy, input logic [DW-1:0] rdata,
                              input logic ack,
                              input logic req, input logic [AW-1:0] addr,
                              input logic v, input logic [DW-1:0] ins,
                              input logic [AW-1:0] ipc);
    vec_t t;
    t.name = name; t.rst = rst; t.ph = ph; t.st = st; t.ld = ld; t.ldv = ldv;
    t.rdy = rdy; t.rdata = rdata; t.ack = ack;
    t.req = req; t.addr = addr; t.v = v; t.ins = ins; t.ipc = ipc;
    return t;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive one vector, clock it, then compare all outputs 1ns after the edge.
  task automatic step(input vec_t t);
    logic [DW-1:0] ins_e;
    reset = t.rst; phase_if = t.ph; stall = t.st; pc_load = t.ld;
    pc_load_value = t.ldv; imem_ready = t.rdy; imem_rdata = t.rdata; id_ack = t.ack;
    @(posedge clk);
    #1;
    ins_e = t.ins;
    check({t.name, ".imem_req"},    {31'd0, imem_req},    {31'd0, t.req});
    check({t.name, ".imem_addr"},   {16'd0, imem_addr},   {16'd0, t.addr});
    check({t.name, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, t.v});
    check({t.name, ".instr"},       instr,                t.ins);
    check({t.name, ".instr_op"},    {26'd0, instr_op},    {26'd0, ins_e[5:0]});
    check({t.name, ".instr_pc"},    {16'd0, instr_pc},    {16'd0, t.ipc});
    $display("step %-10s req=%0b addr=%04h valid=%0b instr=%08h pc=%04h",
             t.name, imem_req, imem_addr, instr_valid, instr, instr_pc);
  endtask

  initial begin
    reset = 1'b1; phase_if = 1'b0; stall = 1'b0; pc_load = 1'b0;
    pc_load_value = '0; imem_ready = 1'b0; imem_rdata = '0; id_ack = 1'b0;
    @(negedge clk);

    //                  name        rst ph st ld ldv       rdy rdata          ack  req addr      v  instr          ipc
    // basic fetch, one-cycle memory
    tbl.push_back(mk("reset",     1, 0, 0, 0, 16'h0000, 0, 32'h0,         0,   0, 16'h0010, 0, 32'h0,         16'h0000));
    tbl.push_back(mk("b_ph",      0, 1, 0, 0, 16'h0000, 0, 32'h0,         0,   1, 16'h0010, 0, 32'h0,         16'h0000));
    tbl.push_back(mk("b_rdy",     0, 0, 0, 0, 16'h0000, 1, 32'h00000041,  0,   0, 16'h0010, 1, 32'h00000041,  16'h0010));
    tbl.push_back(mk("b_hold",    0, 0, 0, 0, 16'h0000, 0, 32'h0,         0,   0, 16'h0010, 1, 32'h00000041,  16'h0010));
    tbl.push_back(mk("b_ack",     0, 0, 0, 0, 16'h0000, 0, 32'h0,         1,   0, 16'h0010, 0, 32'h00000041,  16'h0010));
    // four-cycle memory wait at pc 0x0011
    tbl.push_back(mk("w_ph",      0, 1, 0, 0, 16'h0000, 0, 32'h0,         0,   1, 16'h0011, 0, 32'h00000041,  16'h0010));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk("w_wait",  0, 0, 0, 0, 16'h0000, 0, 32'hFFFFFFFF,  0,   1, 16'h0011, 0, 32'h00000041,  16'h0010));
    tbl.push_back(mk("w_rdy",     0, 0, 0, 0, 16'h0000, 1, 32'hAABBCC05,  0,   0, 16'h0011, 1, 32'hAABBCC05,  16'h0011));
    tbl.push_back(mk("w_ack",     0, 0, 0, 0, 16'h0000, 0, 32'h0,         1,   0, 16'h0011, 0, 32'hAABBCC05,  16'h0011));
    // redirect to 0x0200 while in REQ; stale word dropped
    tbl.push_back(mk("r_ph",      0, 1, 0, 0, 16'h0000, 0, 32'h0,         0,   1, 16'h0012, 0, 32'hAABBCC05,  16'h0011));
    tbl.push_back(mk("r_load",    0, 0, 0, 1, 16'h0200, 0, 32'h0,         0,   1, 16'h0012, 0, 32'hAABBCC05,  16'h0011));
    tbl.push_back(mk("r_stale",   0, 0, 0, 0, 16'h0000, 1, 32'hDEAD0001,  0,   0, 16'h0012, 0, 32'hAABBCC05,  16'h0011));
    tbl.push_back(mk("r_ph2",     0, 1, 0, 0, 16'h0000, 0, 32'h0,         0,   1, 16'h0200, 0, 32'hAABBCC05,  16'h0011));
    tbl.push_back(mk("r_rdy",     0, 0, 0, 0, 16'h0000, 1, 32'h00000123,  0,   0, 16'h0200, 1, 32'h00000123,  16'h0200));
    // two pulses while decode withholds ack: one merged fetch afterwards
    tbl.push_back(mk("p_ph1",     0, 1, 0, 0, 16'h0000, 0, 32'h0,         0,   0, 16'h0200, 1, 32'h00000123,  16'h0200));
    tbl.push_back(mk("p_ph2",     0, 1, 0, 0, 16'h0000, 0, 32'h0,         0,   0, 16'h0200, 1, 32'h00000123,  16'h0200));
    tbl.push_back(mk("p_wait",    0, 0, 0, 0, 16'h0000, 0, 32'h0,         0,   0, 16'h0200, 1, 32'h00000123,  16'h0200));
    tbl.push_back(mk("p_ack",     0, 0, 0, 0, 16'h0000, 0, 32'h0,         1,   1, 16'h0201, 0, 32'h00000123,  16'h0200));
    tbl.push_back(mk("p_rdy",     0, 0, 0, 0, 16'h0000, 1, 32'h00000456,  0,   0, 16'h0201, 1, 32'h00000456,  16'h0201));
    tbl.push_back(mk("p_ack2",    0, 0, 0, 0, 16'h0000, 0, 32'h0,         1,   0, 16'h0201, 0, 32'h00000456,  16'h0201));
    tbl.push_back(mk("p_none1",   0, 0, 0, 0, 16'h0000, 0, 32'h0,         0,   0, 16'h0201, 0, 32'h00000456,  16'h0201));
    tbl.push_back(mk("p_none2",   0, 0, 0, 0, 16'h0000, 0, 32'h0,         0,   0, 16'h0201, 0, 32'h00000456,  16'h0201));
    // stall blocks the start; release issues from pending
    tbl.push_back(mk("s_ph",      0, 1, 1, 0, 16'h0000, 0, 32'h0,         0,   0, 16'h0201, 0, 32'h00000456,  16'h0201));
    tbl.push_back(mk("s_hold",    0, 0, 1, 0, 16'h0000, 0, 32'h0,         0,   0, 16'h0201, 0, 32'h00000456,  16'h0201));
    tbl.push_back(mk("s_rel",     0, 0, 0, 0, 16'h0000, 0, 32'h0,         0,   1, 16'h0202, 0, 32'h00000456,  16'h0201));
    tbl.push_back(mk("s_rdy",     0, 0, 0, 0, 16'h0000, 1, 32'h00000789,  0,   0, 16'h0202, 1, 32'h00000789,  16'h0202));
    tbl.push_back(mk("s_ack",     0, 0, 0, 0, 16'h0000, 0, 32'h0,         1,   0, 16'h0202, 0, 32'h00000789,  16'h0202));
    // redirect coinciding with ready: word discarded, pc not incremented
    tbl.push_back(mk("c_ph",      0, 1, 0, 0, 16'h0000, 0, 32'h0,         0,   1, 16'h0203, 0, 32'h00000789,  16'h0202));
    tbl.push_back(mk("c_rdyld",   0, 0, 0, 1, 16'h0300, 1, 32'h00000999,  0,   0, 16'h0203, 0, 32'h00000789,  16'h0202));
    tbl.push_back(mk("c_ph2",     0, 1, 0, 0, 16'h0000, 0, 32'h0,         0,   1, 16'h0300, 0, 32'h00000789,  16'h0202));
    tbl.push_back(mk("c_rdy",     0, 0, 0, 0, 16'h0000, 1, 32'h0000000A,  0,   0, 16'h0300, 1, 32'h0000000A,  16'h0300));
    tbl.push_back(mk("c_ack",     0, 0, 0, 0, 16'h0000, 0, 32'h0,         1,   0, 16'h0300, 0, 32'h0000000A,  16'h0300));

    foreach (tbl[i]) step(tbl[i]);

    // Hand sequence: PC wrap from 0xFFFF, then reset in the middle of a request.
    step(mk("x_load",   0, 0, 0, 1, 16'hFFFF, 0, 32'h0,        0, 0, 16'h0300, 0, 32'h0000000A, 16'h0300));
    step(mk("x_ph",     0, 1, 0, 0, 16'h0000, 0, 32'h0,        0, 1, 16'hFFFF, 0, 32'h0000000A, 16'h0300));
    step(mk("x_rdy",    0, 0, 0, 0, 16'h0000, 1, 32'h0000003F, 0, 0, 16'hFFFF, 1, 32'h0000003F, 16'hFFFF));
    step(mk("x_ack",    0, 0, 0, 0, 16'h0000, 0, 32'h0,        1, 0, 16'hFFFF, 0, 32'h0000003F, 16'hFFFF));
    step(mk("x_wrap",   0, 1, 0, 0, 16'h0000, 0, 32'h0,        0, 1, 16'h0000, 0, 32'h0000003F, 16'hFFFF));
    step(mk("x_rdy2",   0, 0, 0, 0, 16'h0000, 1, 32'h00000055, 0, 0, 16'h0000, 1, 32'h00000055, 16'h0000));
    step(mk("x_phack",  0, 1, 0, 0, 16'h0000, 0, 32'h0,        1, 0, 16'h0000, 0, 32'h00000055, 16'h0000));
    step(mk("x_pend",   0, 0, 0, 0, 16'h0000, 0, 32'h0,        0, 1, 16'h0001, 0, 32'h00000055, 16'h0000));
    step(mk("x_reset",  1, 0, 0, 0, 16'h0000, 0, 32'h0,        0, 0, 16'h0010, 0, 32'h0,        16'h0000));
    step(mk("x_after",  0, 1, 0, 0, 16'h0000, 0, 32'h0,        0, 1, 16'h0010, 0, 32'h0,        16'h0000));
    step(mk("x_rdy3",   0, 0, 0, 0, 16'h0000, 1, 32'h00000081, 0, 0, 16'h0010, 1, 32'h00000081, 16'h0010));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
